instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Fetch stage of the pipeline datapath. Acts as the reader side of the instruction memory: it holds the PC, drives the memory read address, and captures the returned instruction into the IF/ID pipeline register.
- Supports stall, branch redirect with flush, and halt detection.
- Sits between instruction_mem and the decode stage.

Parameters:
ADDR_W, 8, width of PC and instruction memory address
INST_W, 16, instruction width
PC_STEP, 2, byte increment per instruction (word-aligned, even addresses)
HALT_OP, 4'hF, opcode in inst[15:12] that halts fetch
NOP_INST, 16'h0000, instruction inserted into IF/ID on flush or bubble

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
imem_addr  output  ADDR_W  read address to instruction_mem; equals the PC register
imem_data  input  INST_W  instruction returned by instruction_mem, combinational from imem_addr
stall  input  1  hazard unit stall; holds PC and IF/ID
branch_taken  input  1  redirect request from EX stage
branch_target  input  ADDR_W  redirect address; bit 0 ignored and forced to 0
ifid_inst  output  INST_W  IF/ID instruction register
ifid_pc  output  ADDR_W  PC of the instruction in IF/ID
ifid_valid  output  1  IF/ID holds a real instruction
halted  output  1  fetch stopped on HALT_OP

Behaviour:
- Reset is asynchronous and overrides everything. On reset: pc=0, imem_addr=0, ifid_inst=NOP_INST, ifid_pc=0, ifid_valid=0, halted=0, state=BOOT.
- States: BOOT, RUN, HALT.
- BOOT lasts one rising edge after rst deasserts. No capture occurs and PC does not advance. It then moves to RUN. It absorbs the memory's first-read settling.
- RUN, evaluated each edge in strict priority order:
  1. branch_taken: pc <= {branch_target[ADDR_W-1:1],1'b0}; ifid_inst <= NOP_INST; ifid_valid <= 0 (flush the wrong-path instruction).
  2. stall: pc, ifid_inst, ifid_pc and ifid_valid all hold their values.
  3. Otherwise: ifid_inst <= imem_data; ifid_pc <= pc; ifid_valid <= 1; pc <= pc + PC_STEP.
- Halt detection in RUN: a normal capture with imem_data[15:12]==HALT_OP captures the halt instruction with valid=1, freezes pc at the halt address, and sets state=HALT and halted=1 on the same edge.
- HALT: pc frozen, no capture. Next edge without stall gives ifid_inst <= NOP_INST and ifid_valid <= 0; the bubble then holds. branch_taken in HALT performs the redirect and flush, clears halted, and returns to RUN. stall in HALT holds everything.
- branch_taken in BOOT is ignored.
- PC wraps modulo 2^ADDR_W: 8'hFE + 2 -> 8'h00. There is no error flag.
- Latency: the instruction at address A appears on ifid_inst one edge after imem_addr==A with no stall or branch.
- Simultaneous stall + branch_taken: the branch wins and the flush occurs.
- Reset asserted mid-stream clears all state immediately, without waiting for a clock. After release, the BOOT cycle precedes fetch from 0.
- Only pc and state are state elements besides the IF/ID register. imem_addr has no combinational path from any input.

Test Plan:
- Reset/boot: rst high 10 ns, release; memory holds 0x1234@0, 0x5678@2, 0x9ABC@4 -> imem_addr=0, valid=0 during BOOT. Then ifid_inst 1234/5678/9ABC with ifid_pc 0/2/4 on successive edges.
- Stall: assert stall for 2 cycles while imem_addr=4 -> imem_addr stays 4 and ifid_inst stays 5678 with valid=1. On release, 9ABC is captured and pc=6.
- Branch: branch_taken=1, branch_target=8'h3B while pc=6 -> next edge pc=8'h3A, ifid_inst=0000, valid=0. Following edge captures mem[58] with ifid_pc=8'h3A.
- Stall+branch same cycle: stall=1, branch_taken=1, target=8'h10 -> pc=8'h10 and flush occurs; the stall is ignored.
- Halt: mem[6]=16'hF000 -> F000 captured with valid=1, halted=1, pc stays 6. The next edge gives valid=0 and the state holds across 5 cycles. branch_taken with target 0 then clears halted and refetches from 0.
- Wrap and async reset: start at pc=8'hFE -> next pc=8'h00. Pulse rst for 3 ns between clock edges -> all outputs reset immediately, before the next edge.

Source files
------------

// File: rtl/instruction_fetch.sv
// ============================================================================
// Module  : instruction_fetch
// Brief   : Fetch stage: PC, instruction memory read address, IF/ID register,
//           with stall, branch redirect/flush and halt detection.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module instruction_fetch #(
  parameter int                ADDR_W   = 8,
  parameter int                INST_W   = 16,
  parameter int                PC_STEP  = 2,
  parameter logic [3:0]        HALT_OP  = 4'hF,
  parameter logic [INST_W-1:0] NOP_INST = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_data,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [INST_W-1:0] ifid_inst,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic              ifid_valid,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(1);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [INST_W-1:0] inst_next;
  logic [ADDR_W-1:0] ipc_next;
  logic              valid_next;

  logic              is_halt_op;
  logic [ADDR_W-1:0] redirect_pc;

  assign is_halt_op  = (imem_data[INST_W-1 -: 4] == HALT_OP);
  assign redirect_pc = branch_target & ALIGN_MASK;

  // Outputs come straight from registers so imem_addr never sees an input path.
  assign imem_addr = pc;
  assign halted    = (state == HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      pc         <= '0;
      ifid_inst  <= NOP_INST;
      ifid_pc    <= '0;
      ifid_valid <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      ifid_inst  <= inst_next;
      ifid_pc    <= ipc_next;
      ifid_valid <= valid_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    inst_next  = ifid_inst;
    ipc_next   = ifid_pc;
    valid_next = ifid_valid;

    case (state)
      BOOT: begin
        state_next = RUN;
      end

      RUN: begin
        if (branch_taken) begin
          pc_next    = redirect_pc;
          inst_next  = NOP_INST;
          valid_next = 1'b0;
        end else if (!stall) begin
          inst_next  = imem_data;
          ipc_next   = pc;
          valid_next = 1'b1;
          // A halt instruction is captured but the PC stays parked on it.
          if (is_halt_op) begin
            state_next = HALT;
          end else begin
            pc_next = pc + PC_INC;
          end
        end
      end

      HALT: begin
        if (branch_taken) begin
          pc_next    = redirect_pc;
          inst_next  = NOP_INST;
          valid_next = 1'b0;
          state_next = RUN;
        end else if (!stall) begin
          inst_next  = NOP_INST;
          valid_next = 1'b0;
        end
      end

      default: begin
        state_next = BOOT;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// Module  : tb_instruction_fetch
// Brief   : Directed scoreboard bench for instruction_fetch.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [15:0] ifid_inst;
  logic [7:0]  ifid_pc;
  logic        ifid_valid;
  logic        halted;

  logic [15:0] mem [0:255];

  int total;
  int bad;

  typedef struct {
    logic [15:0] inst;
    logic [7:0]  ipc;
    logic        valid;
    logic [7:0]  addr;
    logic        halt;
    logic        chk_pc;
  } exp_t;

  exp_t sb [$];

  instruction_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .ifid_inst     (ifid_inst),
    .ifid_pc       (ifid_pc),
    .ifid_valid    (ifid_valid),
    .halted        (halted)
  );

  assign imem_data = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, ".inst"},  ifid_inst, e.inst);
    check({tag, ".valid"}, 16'(ifid_valid), 16'(e.valid));
    check({tag, ".addr"},  16'(imem_addr), 16'(e.addr));
    check({tag, ".halt"},  16'(halted), 16'(e.halt));
    if (e.chk_pc) check({tag, ".ifid_pc"}, 16'(ifid_pc), 16'(e.ipc));
  endtask

  // Push the expected post-edge outputs, clock once, then pop and compare.
  task automatic step(input string tag, input logic [15:0] ei, input logic [7:0] ep,
                      input logic ev, input logic [7:0] ea, input logic eh, input logic cp);
    exp_t e;
    e.inst = ei; e.ipc = ep; e.valid = ev; e.addr = ea; e.halt = eh; e.chk_pc = cp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      e = sb.pop_front();
      check_outputs(tag, e);
    end
  endtask

  initial begin
    exp_t r;
    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h1234;
    mem[8'h02] = 16'h5678;
    mem[8'h04] = 16'h9ABC;
    mem[8'h06] = 16'hF000;
    mem[8'h3A] = 16'h1111;
    mem[8'hFE] = 16'h2222;

    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    r.inst = 16'h0000; r.ipc = 8'h00; r.valid = 1'b0; r.addr = 8'h00; r.halt = 1'b0; r.chk_pc = 1'b1;
    #10;
    rst = 1'b0;
    #2;
    check_outputs("reset", r);

    step("boot",  16'h0000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    step("f0",    16'h1234, 8'h00, 1'b1, 8'h02, 1'b0, 1'b1);
    step("f2",    16'h5678, 8'h02, 1'b1, 8'h04, 1'b0, 1'b1);

    stall = 1'b1;
    step("stall1", 16'h5678, 8'h02, 1'b1, 8'h04, 1'b0, 1'b1);
    step("stall2", 16'h5678, 8'h02, 1'b1, 8'h04, 1'b0, 1'b1);
    stall = 1'b0;
    step("f4",    16'h9ABC, 8'h04, 1'b1, 8'h06, 1'b0, 1'b1);

    branch_taken = 1'b1; branch_target = 8'h3B;
    step("br3b",  16'h0000, 8'h00, 1'b0, 8'h3A, 1'b0, 1'b0);
    branch_taken = 1'b0;
    step("f3a",   16'h1111, 8'h3A, 1'b1, 8'h3C, 1'b0, 1'b1);

    stall = 1'b1; branch_taken = 1'b1; branch_target = 8'h10;
    step("stbr",  16'h0000, 8'h00, 1'b0, 8'h10, 1'b0, 1'b0);
    stall = 1'b0; branch_target = 8'h06;
    step("br06",  16'h0000, 8'h00, 1'b0, 8'h06, 1'b0, 1'b0);
    branch_taken = 1'b0;
    step("halt",  16'hF000, 8'h06, 1'b1, 8'h06, 1'b1, 1'b1);
    stall = 1'b1;
    step("hstall", 16'hF000, 8'h06, 1'b1, 8'h06, 1'b1, 1'b1);
    stall = 1'b0;
    for (int i = 0; i < 5; i++)
      step("hbub", 16'h0000, 8'h00, 1'b0, 8'h06, 1'b1, 1'b0);

    branch_taken = 1'b1; branch_target = 8'h00;
    step("hbr",   16'h0000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    branch_taken = 1'b0;
    step("refetch", 16'h1234, 8'h00, 1'b1, 8'h02, 1'b0, 1'b1);

    branch_taken = 1'b1; branch_target = 8'hFF;
    step("brff",  16'h0000, 8'h00, 1'b0, 8'hFE, 1'b0, 1'b0);
    branch_taken = 1'b0;
    step("wrap",  16'h2222, 8'hFE, 1'b1, 8'h00, 1'b0, 1'b1);
    step("f0w",   16'h1234, 8'h00, 1'b1, 8'h02, 1'b0, 1'b1);

    // Short reset pulse placed between clock edges.
    #1;
    rst = 1'b1;
    #1;
    check_outputs("arst", r);
    #2;
    rst = 1'b0;
    #1;
    check_outputs("arst_rel", r);
    step("boot2", 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    step("f0b",   16'h1234, 8'h00, 1'b1, 8'h02, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
